// File: rtl/alien_formation_mover_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alien_formation_mover_pkg
// Description : Shared game definitions for the alien formation: motion
//               command encodings, screen-bound constants and a saturating
//               subtract used by the step-period logic.
// Revision    : 1.0 - initial release
// ============================================================================
package alien_formation_mover_pkg;

  // Commands issued by the zig-zag controller
  typedef enum logic [1:0] {
    NO_MOTION = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2,
    DOWN      = 2'd3
  } motion_e;

  // Screen bounds for the formation's left/top edge
  localparam int unsigned c_SCREEN_X_MIN   = 8;
  localparam int unsigned c_SCREEN_X_MAX   = 440;
  localparam int unsigned c_SCREEN_Y_LIMIT = 400;

  // Datapath widths
  localparam int unsigned c_POS_W = 10;
  localparam int unsigned c_CNT_W = 16;

  // value - dec, but never below floor (and never wrapping below zero)
  function automatic logic [c_CNT_W-1:0] sat_sub(
    input logic [c_CNT_W-1:0] value,
    input logic [c_CNT_W-1:0] dec,
    input logic [c_CNT_W-1:0] floor
  );
    logic [c_CNT_W:0] lim;
    lim = {1'b0, floor} + {1'b0, dec};
    if ({1'b0, value} >= lim) begin
      sat_sub = value - dec;
    end else begin
      sat_sub = floor;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/alien_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : alien_step_timer
// Description : Step-rate divider. Counts enabled cycles and emits a tick on
//               the last count of the current period; a speed-up request in
//               a tick cycle shortens the period (down to a floor) starting
//               with the next count.
// Revision    : 1.0 - initial release
// ============================================================================
module alien_step_timer
  import alien_formation_mover_pkg::*;
#(
  parameter int unsigned PERIOD_INIT = 20,
  parameter int unsigned PERIOD_MIN  = 4,
  parameter int unsigned PERIOD_DEC  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic speedUp,
  output logic tick
);

  localparam logic [c_CNT_W-1:0] c_PERIOD_INIT = c_CNT_W'(PERIOD_INIT);
  localparam logic [c_CNT_W-1:0] c_PERIOD_MIN  = c_CNT_W'(PERIOD_MIN);
  localparam logic [c_CNT_W-1:0] c_PERIOD_DEC  = c_CNT_W'(PERIOD_DEC);

  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;
  logic [c_CNT_W-1:0] period_q;
  logic [c_CNT_W-1:0] period_d;

  // A pending tick is suppressed while reset is asserted so reset always wins
  assign tick = run && !reset && (cnt_q == (period_q - c_CNT_W'(1)));

  // Next count and period: wrap on tick, optionally shortening the period
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (run) begin
      if (tick) begin
        cnt_d = '0;
        if (speedUp) begin
          period_d = sat_sub(period_q, c_PERIOD_DEC, c_PERIOD_MIN);
        end
      end else begin
        cnt_d = cnt_q + c_CNT_W'(1);
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= c_PERIOD_INIT;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alien_formation_mover.sv
`default_nettype none
// ============================================================================
// Module      : alien_formation_mover
// Description : Moves the alien formation one step per timer tick according
//               to the controller's motion command, keeping the left edge
//               inside the screen and latching a landed flag when the top
//               edge reaches the landing line.
// Revision    : 1.0 - initial release
// ============================================================================
module alien_formation_mover
  import alien_formation_mover_pkg::*;
#(
  parameter int unsigned X_INIT      = 64,
  parameter int unsigned Y_INIT      = 32,
  parameter int unsigned X_MIN       = c_SCREEN_X_MIN,
  parameter int unsigned X_MAX       = c_SCREEN_X_MAX,
  parameter int unsigned STEP_X      = 4,
  parameter int unsigned STEP_Y      = 16,
  parameter int unsigned Y_LIMIT     = c_SCREEN_Y_LIMIT,
  parameter int unsigned PERIOD_INIT = 20,
  parameter int unsigned PERIOD_MIN  = 4,
  parameter int unsigned PERIOD_DEC  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         Motion,
  output logic               step,
  output logic [c_POS_W-1:0] xPos,
  output logic [c_POS_W-1:0] yPos,
  output logic               canLeft,
  output logic               canRight,
  output logic               landed
);

  // Bound arithmetic is done one bit wider than the position so sums
  // near the top of the 10-bit range cannot wrap.
  localparam logic [c_POS_W:0]   c_LEFT_MIN  = (c_POS_W + 1)'(X_MIN + STEP_X);
  localparam logic [c_POS_W:0]   c_X_MAX_W   = (c_POS_W + 1)'(X_MAX);
  localparam logic [c_POS_W:0]   c_STEP_X_W  = (c_POS_W + 1)'(STEP_X);
  localparam logic [c_POS_W:0]   c_STEP_Y_W  = (c_POS_W + 1)'(STEP_Y);
  localparam logic [c_POS_W:0]   c_Y_LIMIT_W = (c_POS_W + 1)'(Y_LIMIT);
  localparam logic [c_POS_W-1:0] c_STEP_X_N  = c_POS_W'(STEP_X);
  localparam logic [c_POS_W-1:0] c_Y_LIMIT_N = c_POS_W'(Y_LIMIT);
  localparam logic [c_POS_W-1:0] c_X_INIT    = c_POS_W'(X_INIT);
  localparam logic [c_POS_W-1:0] c_Y_INIT    = c_POS_W'(Y_INIT);

  logic [c_POS_W-1:0] xpos_q;
  logic [c_POS_W-1:0] xpos_d;
  logic [c_POS_W-1:0] ypos_q;
  logic [c_POS_W-1:0] ypos_d;
  logic               landed_q;
  logic               landed_d;

  motion_e            w_motion;
  logic               w_run;
  logic               w_tick;
  logic               w_speed_up;
  logic [c_POS_W:0]   w_x_wide;
  logic [c_POS_W:0]   w_x_sum;
  logic [c_POS_W-1:0] w_x_dif;
  logic [c_POS_W:0]   w_y_sum;

  assign w_motion   = motion_e'(Motion);
  assign w_run      = enable && !landed_q;
  assign w_speed_up = (w_motion == DOWN);

  assign w_x_wide = {1'b0, xpos_q};
  assign w_x_sum  = w_x_wide + c_STEP_X_W;
  assign w_x_dif  = xpos_q - c_STEP_X_N;
  assign w_y_sum  = {1'b0, ypos_q} + c_STEP_Y_W;

  assign canLeft  = (w_x_wide >= c_LEFT_MIN);
  assign canRight = (w_x_sum <= c_X_MAX_W);

  alien_step_timer #(
    .PERIOD_INIT (PERIOD_INIT),
    .PERIOD_MIN  (PERIOD_MIN),
    .PERIOD_DEC  (PERIOD_DEC)
  ) u_step_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (w_run),
    .speedUp (w_speed_up),
    .tick    (w_tick)
  );

  // Apply the sampled motion command in the tick cycle only
  always_comb begin
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    landed_d = landed_q;
    if (w_tick) begin
      unique case (w_motion)
        LEFT: begin
          if (canLeft) xpos_d = w_x_dif;
        end
        RIGHT: begin
          if (canRight) xpos_d = w_x_sum[c_POS_W-1:0];
        end
        DOWN: begin
          if (w_y_sum >= c_Y_LIMIT_W) begin
            ypos_d   = c_Y_LIMIT_N;
            landed_d = 1'b1;
          end else begin
            ypos_d = w_y_sum[c_POS_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Formation position and landed flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      xpos_q   <= c_X_INIT;
      ypos_q   <= c_Y_INIT;
      landed_q <= 1'b0;
    end else begin
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      landed_q <= landed_d;
    end
  end

  assign step   = w_tick;
  assign xPos   = xpos_q;
  assign yPos   = ypos_q;
  assign landed = landed_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_formation_mover.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alien_formation_mover
// Description : Scoreboard bench for alien_formation_mover. The driver queues
//               the expected cycle and resulting position of every step; a
//               monitor compares each observed step against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alien_formation_mover;

  typedef struct {
    int cyc;
    int x;
    int y;
    int landed;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] Motion;
  logic       step;
  logic [9:0] xPos;
  logic [9:0] yPos;
  logic       canLeft;
  logic       canRight;
  logic       landed;

  logic       e_enable;
  logic [1:0] e_motion;
  logic       e_step;
  logic [9:0] e_xPos;
  logic [9:0] e_yPos;
  logic       e_canLeft;
  logic       e_canRight;
  logic       e_landed;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_steps  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alien_formation_mover dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .Motion   (Motion),
    .step     (step),
    .xPos     (xPos),
    .yPos     (yPos),
    .canLeft  (canLeft),
    .canRight (canRight),
    .landed   (landed)
  );

  // Second instance starting next to the right edge and the landing line
  alien_formation_mover #(
    .X_INIT (436),
    .Y_INIT (392)
  ) dut_e (
    .clk      (clk),
    .reset    (reset),
    .enable   (e_enable),
    .Motion   (e_motion),
    .step     (e_step),
    .xPos     (e_xPos),
    .yPos     (e_yPos),
    .canLeft  (e_canLeft),
    .canRight (e_canRight),
    .landed   (e_landed)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expect_step(input int t, input int x, input int y, input int l);
    exp_t e;
    e.cyc = t; e.x = x; e.y = y; e.landed = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed step is matched against the head of the queue;
  // the position is compared on the following negedge, after the update.
  logic pend = 1'b0;
  int   step_cyc;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      pend = 1'b0;
      e = exp_q.pop_front();
      check("step_cycle", step_cyc, e.cyc);
      check("step_xPos", int'(xPos), e.x);
      check("step_yPos", int'(yPos), e.y);
      check("step_landed", int'(landed), e.landed);
    end
    if (step === 1'b1) begin
      n_steps++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_step: step=1 at cycle %0d, expected no step", cyc);
      end else begin
        pend     = 1'b1;
        step_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, t, x, y, p, ce, e_cnt;

    reset = 1'b1; enable = 1'b0; Motion = 2'd0;
    e_enable = 1'b0; e_motion = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_xPos", int'(xPos), 64);
    check("rst_yPos", int'(yPos), 32);
    check("rst_step", int'(step), 0);
    check("rst_landed", int'(landed), 0);
    check("rst_canLeft", int'(canLeft), 1);
    check("rst_canRight", int'(canRight), 1);
    check("rst_e_xPos", int'(e_xPos), 436);
    check("rst_e_yPos", int'(e_yPos), 392);

    // Reset in the cycle before the first step cancels it
    reset = 1'b0; enable = 1'b1; Motion = 2'd2; c0 = cyc;
    wait_until(c0 + 18);
    check("prestep_quiet", int'(step), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_step", int'(step), 0);
    check("rst2_xPos", int'(xPos), 64);
    check("rst2_yPos", int'(yPos), 32);
    check("rst2_landed", int'(landed), 0);
    reset = 1'b0; c0 = cyc;

    // RIGHT steps: first at cycle 20, enable freeze after the first step,
    // then a walk into the right edge
    x = 64; t = c0 + 19;
    for (int i = 1; i <= 96; i++) begin
      x = (x + 4 > 440) ? 440 : x + 4;
      expect_step(t, x, 32, 0);
      wait_until(t + 1);
      if (i == 1) begin
        wait_until(t + 11);
        enable = 1'b0;
        wait_until(t + 40);
        check("freeze_step", int'(step), 0);
        check("freeze_xPos", int'(xPos), 68);
        wait_until(t + 61);
        enable = 1'b1;
        t = t + 70;
      end else begin
        t = t + 20;
      end
      if (i == 93) begin
        check("edge_x436", int'(xPos), 436);
        check("canRight_at_436", int'(canRight), 1);
      end
      if (i == 94) check("canRight_at_440", int'(canRight), 0);
    end

    // One LEFT step, then DOWN steps with a shrinking period down to landing
    Motion = 2'd1;
    t = t - 20 + 20;
    expect_step(t, 436, 32, 0);
    wait_until(t + 1);
    check("canLeft_at_436", int'(canLeft), 1);
    Motion = 2'd3; p = 20; y = 32;
    for (int k = 1; k <= 23; k++) begin
      t = t + p;
      y = y + 16;
      expect_step(t, 436, y, (k == 23) ? 1 : 0);
      wait_until(t + 1);
      p = (p - 2 < 4) ? 4 : p - 2;
    end
    check("landed_set", int'(landed), 1);

    // Edge instance: right edge clamp, then landing from y=392 with clamp
    e_enable = 1'b1; e_motion = 2'd2; ce = cyc;
    wait_until(ce + 18);
    check("e_prestep", int'(e_step), 0);
    wait_until(ce + 19);
    check("e_step1", int'(e_step), 1);
    wait_until(ce + 20);
    check("e_xPos_440", int'(e_xPos), 440);
    check("e_canRight_0", int'(e_canRight), 0);
    e_motion = 2'd3;
    wait_until(ce + 39);
    check("e_step2", int'(e_step), 1);
    wait_until(ce + 40);
    check("e_yPos_400", int'(e_yPos), 400);
    check("e_landed", int'(e_landed), 1);
    check("e_xPos_hold", int'(e_xPos), 440);
    e_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (e_step === 1'b1) e_cnt++;
    end
    check("e_steps_after_land", e_cnt, 0);
    check("e_yPos_after_land", int'(e_yPos), 400);

    // Main instance after landing: enable still high, nothing moves
    check("land_step", int'(step), 0);
    check("land_flag", int'(landed), 1);
    check("land_yPos", int'(yPos), 400);
    check("land_xPos", int'(xPos), 436);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("step_count", n_steps, 120);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alien_formation_mover.md
ALIEN_FORMATION_MOVER -- requirements
Module: alien_formation_mover

Interface
REQ-001 Parameters SHALL be as follows (one per line: name, default, meaning).
REQ-002 X_INIT, 64, formation left-edge x after reset.
REQ-003 Y_INIT, 32, formation top-edge y after reset.
REQ-004 X_MIN, 8, smallest legal left-edge x.
REQ-005 X_MAX, 440, largest legal left-edge x.
REQ-006 STEP_X, 4, pixels per horizontal step.
REQ-007 STEP_Y, 16, pixels per down step.
REQ-008 Y_LIMIT, 400, y at which the formation has landed.
REQ-009 PERIOD_INIT / PERIOD_MIN / PERIOD_DEC, 20 / 4 / 2, step period in clk cycles: initial value, floor, and decrement per down step.
REQ-010 Ports SHALL be as follows (one per line: name, direction, width, meaning).
REQ-011 clk, in, 1, single clock; all state updates on its rising edge.
REQ-012 reset, in, 1, synchronous, active-high.
REQ-013 enable, in, 1, game-run gate; 0 freezes all state.
REQ-014 Motion, in, 2, command from the zig-zag controller: 0 none, 1 left, 2 right, 3 down.
REQ-015 step, out, 1, one-cycle pulse when a move is applied; drives the controller's enable.
REQ-016 xPos, out, 10, registered formation left-edge x.
REQ-017 yPos, out, 10, registered formation top-edge y.
REQ-018 canLeft, out, 1, combinational: xPos >= X_MIN + STEP_X.
REQ-019 canRight, out, 1, combinational: xPos + STEP_X <= X_MAX, evaluated at 11 bits with no overflow.
REQ-020 landed, out, 1, sticky flag: the formation has reached Y_LIMIT.

Function
REQ-021 A 16-bit divider count cnt SHALL advance only when enable=1 and landed=0.
REQ-022 step SHALL assert in exactly the cycle where the divider advances with cnt == period-1; cnt SHALL then return to 0.
REQ-023 In the step cycle, the block SHALL apply the Motion value sampled in that cycle; xPos, yPos and period SHALL update on the same edge, giving 1-cycle latency.
REQ-024 LEFT SHALL subtract STEP_X from xPos when canLeft=1, and SHALL otherwise hold xPos.
REQ-025 RIGHT SHALL add STEP_X to xPos when canRight=1, and SHALL otherwise hold xPos.
REQ-026 NO_MOTION SHALL hold the position; step SHALL still pulse.
REQ-027 DOWN SHALL set yPos = min(yPos+STEP_Y, Y_LIMIT), computed at 11 bits.
REQ-028 DOWN SHALL also set period = max(period-PERIOD_DEC, PERIOD_MIN).
REQ-029 A new period SHALL take effect from the next count (cnt=0).
REQ-030 When DOWN brings yPos to Y_LIMIT, landed SHALL set on the same edge; it SHALL stay set until reset.
REQ-031 While landed=1, step SHALL remain 0 and position and period SHALL hold.
REQ-032 enable falling mid-count SHALL freeze cnt; the count SHALL resume from the same value when enable returns.
REQ-033 xPos SHALL never leave [X_MIN, X_MAX], and yPos SHALL never exceed Y_LIMIT.

Reset
REQ-034 When reset=1 at a clock edge, the block SHALL set xPos=X_INIT, yPos=Y_INIT, cnt=0, period=PERIOD_INIT, step=0, landed=0.
REQ-035 reset SHALL take priority over enable and any in-progress count.

Structure
REQ-036 Motion encodings (NO_MOTION, LEFT, RIGHT, DOWN) SHALL live in the shared game definitions package, together with the screen-bound constants.
REQ-037 The divider and period logic SHALL be the sub-module alien_step_timer, with inputs clk, reset, run, speedUp and output tick.

Verification
REQ-038 Reset, then enable=1, Motion=2: the bench SHALL see the first step at cycle 20, then xPos 64->68; steps SHALL recur every 20 cycles.
REQ-039 Motion=2 held from xPos=436: xPos SHALL reach 440, canRight SHALL drop to 0, and the next step SHALL leave xPos at 440.
REQ-040 Motion=3 at yPos=32: yPos SHALL become 48, and the next step interval SHALL be 18 cycles; after 8 further DOWN steps, the period SHALL remain at 4.
REQ-041 yPos=392, Motion=3: yPos SHALL become 400 and landed=1, after which no further step SHALL occur with enable=1.
REQ-042 enable dropped at cnt=10 for 50 cycles, then restored: the step SHALL arrive 9 cycles after restore.
REQ-043 reset asserted the cycle before a step: no step SHALL occur, and all outputs SHALL hold their reset values on the next cycle.
